// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding (common with the receiver),
// bit-timing and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    BREAK     = 3'd5,
    BREAK_REC = 3'd6
  } uart_state_t;

  // Widest data word the parity helper accepts; callers zero-extend.
  localparam int PARITY_DATA_W = 64;

  function automatic int cycles_per_bit(input longint clk_freq, input longint baud_rate);
    return int'(clk_freq / baud_rate);
  endfunction

  function automatic logic parity_of(input logic [PARITY_DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: wrap-around counter with synchronous clear and a
// one-cycle bit_end pulse on the last cycle of each bit period.
module uart_baud_gen #(
  parameter int CYCLES_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES_PER_BIT - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear || bit_end) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bit_end = (count_reg == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, N data bits LSB first, optional parity, M stop bits.
// Define UART_TX_BREAK_EN to add the break_req input and line-break states.
module uart_tx
  import uart_pkg::*;
#(
  parameter int N          = 8,
  parameter int M          = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int BAUD_RATE  = 9600,
  parameter int CLK_FREQ   = 50000000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] tx_data,
  input  logic         tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic         break_req,
`endif
  output logic         tx_ready,
  output logic         tx,
  output logic         tx_done,
  output logic         tx_busy
);

  localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int MAX_NM         = (N > M) ? N : M;
  localparam int BIT_W          = $clog2(MAX_NM + 1);

  if (CYCLES_PER_BIT < 2) begin : g_cpb_check
    $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (M < 1 || M > 2) begin : g_stop_check
    $error("uart_tx: M must be 1 or 2");
  end

  uart_state_t      state_reg, state_next;
  logic [N-1:0]     shift_reg, shift_next;
  logic             parity_reg, parity_next;
  logic [BIT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             tx_reg, tx_next;
  logic             bit_end;
  logic             baud_clear;
  logic             done;

  uart_baud_gen #(
    .CYCLES_PER_BIT(CYCLES_PER_BIT)
  ) baud_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (baud_clear),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    bit_cnt_next = bit_cnt_reg;
    baud_clear   = 1'b0;
    done         = 1'b0;

    case (state_reg)
      IDLE: begin
        // Holding the timer cleared makes the first START cycle count 0.
        baud_clear = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (break_req) state_next = BREAK;
        else
`endif
        if (tx_valid) begin
          state_next   = START;
          shift_next   = tx_data;
          parity_next  = parity_of(PARITY_DATA_W'(tx_data), PARITY_ODD != 0);
          bit_cnt_next = '0;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_cnt_reg == BIT_W'(N - 1)) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_reg == BIT_W'(M - 1)) begin
            done         = 1'b1;
            bit_cnt_next = '0;
            state_next   = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      BREAK: begin
        // Timer restarts when break_req drops so recovery is a full bit.
        baud_clear = 1'b1;
        if (!break_req) state_next = BREAK_REC;
      end
      BREAK_REC: begin
        if (bit_end) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Line level is decoded from the upcoming state so tx lines up with state_reg.
  always_comb begin
    tx_next = 1'b1;
    case (state_next)
      START, BREAK: tx_next = 1'b0;
      DATA:         tx_next = shift_next[0];
      PARITY:       tx_next = parity_next;
      default:      tx_next = 1'b1;
    endcase
  end

  assign tx       = tx_reg;
  assign tx_done  = done;
  assign tx_ready = (state_reg == IDLE);
  assign tx_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: four configurations at 16 cycles per bit,
// checked cycle by cycle against a frame-level bit-list model.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [7:0] tx_data  [4];
  logic       tx_valid [4];
  logic       tx_line  [4];
  logic       ready    [4];
  logic       done     [4];
  logic       busy     [4];
`ifdef UART_TX_BREAK_EN
  logic       break_req[4];
`endif

  int tests = 0;
  int fails = 0;

  // d0: 8N1, d1: 8E1, d2: 8O1, d3: 8N2
  uart_tx #(.N(8), .M(1), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_RATE(1), .CLK_FREQ(16)) d0 (
    .clk(clk), .reset(reset), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req[0]),
`endif
    .tx_ready(ready[0]), .tx(tx_line[0]), .tx_done(done[0]), .tx_busy(busy[0]));

  uart_tx #(.N(8), .M(1), .PARITY_EN(1), .PARITY_ODD(0), .BAUD_RATE(1), .CLK_FREQ(16)) d1 (
    .clk(clk), .reset(reset), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req[1]),
`endif
    .tx_ready(ready[1]), .tx(tx_line[1]), .tx_done(done[1]), .tx_busy(busy[1]));

  uart_tx #(.N(8), .M(1), .PARITY_EN(1), .PARITY_ODD(1), .BAUD_RATE(1), .CLK_FREQ(16)) d2 (
    .clk(clk), .reset(reset), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req[2]),
`endif
    .tx_ready(ready[2]), .tx(tx_line[2]), .tx_done(done[2]), .tx_busy(busy[2]));

  uart_tx #(.N(8), .M(2), .PARITY_EN(0), .PARITY_ODD(0), .BAUD_RATE(1), .CLK_FREQ(16)) d3 (
    .clk(clk), .reset(reset), .tx_data(tx_data[3]), .tx_valid(tx_valid[3]),
`ifdef UART_TX_BREAK_EN
    .break_req(break_req[3]),
`endif
    .tx_ready(ready[3]), .tx(tx_line[3]), .tx_done(done[3]), .tx_busy(busy[3]));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Builds the expected line as a list of bit values, then checks every cycle
  // from acceptance+1 to the cycle after tx_done. Returns in the IDLE cycle.
  task automatic run_frame(input int idx, input logic [7:0] data, input bit hold, input logic [7:0] next_data);
    bit bits[$];
    int len, ones, stops;
    bit par_en, odd;
    par_en = (idx == 1) || (idx == 2);
    odd    = (idx == 2);
    stops  = (idx == 3) ? 2 : 1;
    ones   = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (par_en) bits.push_back(odd ? (ones % 2 == 0) : (ones % 2 == 1));
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    len = bits.size() * 16;

    check($sformatf("d%0d idle_ready", idx), 32'(ready[idx]), 1);
    check($sformatf("d%0d idle_tx", idx), 32'(tx_line[idx]), 1);
    check($sformatf("d%0d idle_busy", idx), 32'(busy[idx]), 0);
    tx_valid[idx] = 1'b1;
    tx_data[idx]  = data;
    @(posedge clk); #1;
    if (hold) begin
      tx_data[idx] = next_data;
    end else begin
      tx_valid[idx] = 1'b0;
      tx_data[idx]  = 8'($urandom);
    end
    for (int k = 1; k <= len; k++) begin
      check($sformatf("d%0d tx c%0d", idx, k), 32'(tx_line[idx]), 32'(bits[(k - 1) / 16]));
      check($sformatf("d%0d done c%0d", idx, k), 32'(done[idx]), 32'(k == len));
      check($sformatf("d%0d ready c%0d", idx, k), 32'(ready[idx]), 0);
      check($sformatf("d%0d busy c%0d", idx, k), 32'(busy[idx]), 1);
      @(posedge clk); #1;
    end
    check($sformatf("d%0d done_clear", idx), 32'(done[idx]), 0);
    check($sformatf("d%0d ready_back", idx), 32'(ready[idx]), 1);
    check($sformatf("d%0d tx_idle", idx), 32'(tx_line[idx]), 1);
    $display("[TB] dut%0d frame data=%02h len=%0d cycles", idx, data, len);
  endtask

  initial begin
    bit saw_done, saw_low, saw_busy;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data[i]  = 8'h00;
      tx_valid[i] = 1'b0;
`ifdef UART_TX_BREAK_EN
      break_req[i] = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("d%0d rst_tx", i), 32'(tx_line[i]), 1);
      check($sformatf("d%0d rst_done", i), 32'(done[i]), 0);
      check($sformatf("d%0d rst_ready", i), 32'(ready[i]), 1);
      check($sformatf("d%0d rst_busy", i), 32'(busy[i]), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(ready[0]), 1);

    run_frame(0, 8'hA5, 1'b0, 8'h00);
    run_frame(1, 8'h07, 1'b0, 8'h00);
    run_frame(2, 8'h07, 1'b0, 8'h00);
    // Back-to-back: valid stays high, second word presented right after acceptance
    run_frame(0, 8'h00, 1'b1, 8'hFF);
    run_frame(0, 8'hFF, 1'b0, 8'h00);
    run_frame(3, 8'($urandom), 1'b0, 8'h00);
    for (int r = 0; r < 6; r++) begin
      run_frame(int'($urandom_range(0, 3)), 8'($urandom), 1'b0, 8'h00);
    end

    // Reset during data bit 3 (cycles 65..80 after acceptance)
    tx_valid[0] = 1'b1;
    tx_data[0]  = 8'h00;
    @(posedge clk); #1;
    tx_valid[0] = 1'b0;
    repeat (69) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 32'(busy[0]), 1);
    check("mid_tx_low", 32'(tx_line[0]), 0);
    reset = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx_line[0]), 1);
    check("rst_async_ready", 32'(ready[0]), 1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("rst_hold_tx", 32'(tx_line[0]), 1);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_rel_ready", 32'(ready[0]), 1);
    saw_done = 1'b0;
    saw_low  = 1'b0;
    saw_busy = 1'b0;
    for (int c = 0; c < 200; c++) begin
      saw_done |= done[0];
      saw_low  |= !tx_line[0];
      saw_busy |= busy[0];
      @(posedge clk); #1;
    end
    check("rst_no_done", 32'(saw_done), 0);
    check("rst_no_low", 32'(saw_low), 0);
    check("rst_no_busy", 32'(saw_busy), 0);
    $display("[TB] dut0 reset mid-frame abandoned");
    run_frame(0, 8'($urandom), 1'b0, 8'h00);

`ifdef UART_TX_BREAK_EN
    break_req[0] = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (k == 100) break_req[0] = 1'b0;
      check($sformatf("brk_tx c%0d", k), 32'(tx_line[0]), 0);
      check($sformatf("brk_ready c%0d", k), 32'(ready[0]), 0);
      check($sformatf("brk_busy c%0d", k), 32'(busy[0]), 1);
    end
    for (int k = 101; k <= 116; k++) begin
      @(posedge clk); #1;
      check($sformatf("rec_tx c%0d", k), 32'(tx_line[0]), 1);
      check($sformatf("rec_ready c%0d", k), 32'(ready[0]), 0);
      check($sformatf("rec_busy c%0d", k), 32'(busy[0]), 1);
    end
    @(posedge clk); #1;
    check("brk_idle_ready", 32'(ready[0]), 1);
    check("brk_idle_busy", 32'(busy[0]), 0);
    $display("[TB] dut0 break 100 cycles");
    run_frame(0, 8'($urandom), 1'b0, 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
